// File: rtl/whack_pkg.sv
// Shared types and constants for the whack-a-mole round controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package whack_pkg;

  localparam int LFSR_W = 8;
  // Fibonacci taps for x^8+x^6+x^5+x^4+1 on a left-shifting register (bits 7,5,4,3).
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;
  localparam int MISS_W = 3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SPAWN  = 3'd1,
    ACTIVE = 3'd2,
    HIT    = 3'd3,
    MISS   = 3'd4,
    OVER   = 3'd5
  } state_e;

  // One LFSR step: shift left, XOR of the tapped bits enters at bit 0.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
    return {v[LFSR_W-2:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/mole_lfsr.sv
// Free-running seedable 8-bit LFSR giving a pseudo-random mole index (lfsr mod N).
// Latency: advances every cycle; idx_o is combinational from the current register.
// Backpressure: none, never stalls.
module mole_lfsr
  import whack_pkg::*;
#(
  parameter int                N    = 3,
  parameter logic [LFSR_W-1:0] SEED = 8'hA5,
  localparam int               IW   = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clock,
  input  logic          scoreReset,
  output logic [IW-1:0] idx_o
);

  logic [LFSR_W-1:0] lfsr_q;

  // Shift register: reloads the non-zero seed on reset, otherwise steps every clock.
  always_ff @(posedge clock or posedge scoreReset) begin
    if (scoreReset) lfsr_q <= SEED;
    else            lfsr_q <= lfsr_step(lfsr_q);
  end

  assign idx_o = IW'(lfsr_q % N);

endmodule

// File: rtl/mole_round_ctrl.sv
// Whack-a-mole round sequencer: spawns moles, times rounds, classifies presses, counts misses.
// Latency: start -> score_clr next cycle, mole valid 2 cycles after start; hit -> score_inc next cycle.
// Backpressure: none; build option MOLE_WRONG_PRESS_PENALTY_EN turns a lone wrong press into a miss.
module mole_round_ctrl
  import whack_pkg::*;
#(
  parameter int          NUM_MOLES     = 3,
  parameter int          TIMEOUT_TICKS = 8,
  parameter int          MAX_MISSES    = 3,
  parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
  input  logic                 clock,
  input  logic                 scoreReset,
  input  logic                 start,
  input  logic                 tick,
  input  logic [NUM_MOLES-1:0] hit,
  output logic [NUM_MOLES-1:0] mole,
  output logic                 score_inc,
  output logic                 score_clr,
  output logic [MISS_W-1:0]    misses,
  output logic                 game_over,
  output logic                 busy
);

  localparam int                IW     = $clog2(NUM_MOLES);
  localparam int                TW     = $clog2(TIMEOUT_TICKS);
  localparam logic [TW-1:0]     T_LAST = TW'(TIMEOUT_TICKS - 1);
  localparam logic [MISS_W-1:0] M_MAX  = MISS_W'(MAX_MISSES);

  state_e                 state_q, state_d;
  logic [NUM_MOLES-1:0]   mole_q, mole_d;
  logic [NUM_MOLES-1:0]   hit_q;
  logic                   inc_q, inc_d;
  logic                   clr_q, clr_d;
  logic [MISS_W-1:0]      misses_q, misses_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic [IW-1:0]          idx;
  logic [NUM_MOLES-1:0]   rise;
  logic                   good_press;
  logic                   any_press;
  logic [MISS_W-1:0]      miss_inc;

  mole_lfsr #(
    .N    (NUM_MOLES),
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clock      (clock),
    .scoreReset (scoreReset),
    .idx_o      (idx)
  );

  // Only fresh presses count; a button already held when the mole appears is not a hit.
  assign rise       = hit & ~hit_q;
  assign good_press = |(rise & mole_q);
  assign any_press  = |rise;
  assign miss_inc   = (misses_q >= M_MAX) ? M_MAX : misses_q + MISS_W'(1);

  // Next-state logic: round sequencing, strobe generation and miss accounting.
  always_comb begin
    state_d  = state_q;
    mole_d   = mole_q;
    inc_d    = 1'b0;
    clr_d    = 1'b0;
    misses_d = misses_q;
    timer_d  = timer_q;
    case (state_q)
      IDLE, OVER: begin
        mole_d = '0;
        if (start) begin
          state_d  = SPAWN;
          clr_d    = 1'b1;
          misses_d = '0;
        end
      end
      SPAWN: begin
        mole_d  = NUM_MOLES'(1) << idx;
        timer_d = '0;
        state_d = ACTIVE;
      end
      ACTIVE: begin
        if (good_press) begin
          // Correct button wins over a simultaneous wrong press or timeout.
          state_d = HIT;
          mole_d  = '0;
          inc_d   = 1'b1;
        end else if (any_press) begin
`ifdef MOLE_WRONG_PRESS_PENALTY_EN
          state_d = MISS;
          mole_d  = '0;
`else
          state_d = ACTIVE;
`endif
        end else if (tick) begin
          if (timer_q == T_LAST) begin
            state_d = MISS;
            mole_d  = '0;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
      end
      HIT: begin
        state_d = SPAWN;
      end
      MISS: begin
        misses_d = miss_inc;
        state_d  = (miss_inc == M_MAX) ? OVER : SPAWN;
      end
      default: begin
        state_d = IDLE;
        mole_d  = '0;
      end
    endcase
  end

  // State and output registers; reset abandons any round without emitting strobes.
  always_ff @(posedge clock or posedge scoreReset) begin
    if (scoreReset) begin
      state_q  <= IDLE;
      mole_q   <= '0;
      inc_q    <= 1'b0;
      clr_q    <= 1'b0;
      misses_q <= '0;
      timer_q  <= '0;
    end else begin
      state_q  <= state_d;
      mole_q   <= mole_d;
      inc_q    <= inc_d;
      clr_q    <= clr_d;
      misses_q <= misses_d;
      timer_q  <= timer_d;
    end
  end

  // Button history for edge detection, tracked in every state.
  always_ff @(posedge clock or posedge scoreReset) begin
    if (scoreReset) hit_q <= '0;
    else            hit_q <= hit;
  end

  assign mole      = mole_q;
  assign score_inc = inc_q;
  assign score_clr = clr_q;
  assign misses    = misses_q;
  assign game_over = (state_q == OVER);
  assign busy      = (state_q != IDLE) && (state_q != OVER);

endmodule

// File: tb/tb_mole_round_ctrl.sv
// Directed bench for mole_round_ctrl (NUM_MOLES=3, TIMEOUT_TICKS=4, MAX_MISSES=3).
// Expected moles come from an independent LFSR model reset alongside the DUT.
// Prints one summary line and finishes.
module tb_mole_round_ctrl;

  logic       clock = 1'b0;
  logic       scoreReset = 1'b1;
  logic       start = 1'b0;
  logic       tick = 1'b0;
  logic [2:0] hit = 3'b000;
  logic [2:0] mole;
  logic       score_inc;
  logic       score_clr;
  logic [2:0] misses;
  logic       game_over;
  logic       busy;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] m_lfsr;
  logic [2:0] exp_mole;

  mole_round_ctrl #(
    .NUM_MOLES     (3),
    .TIMEOUT_TICKS (4),
    .MAX_MISSES    (3),
    .LFSR_SEED     (8'hA5)
  ) dut (
    .clock      (clock),
    .scoreReset (scoreReset),
    .start      (start),
    .tick       (tick),
    .hit        (hit),
    .mole       (mole),
    .score_inc  (score_inc),
    .score_clr  (score_clr),
    .misses     (misses),
    .game_over  (game_over),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] nxt(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  function automatic logic [2:0] onehot_of(input logic [7:0] v);
    logic [2:0] r;
    r = 3'b001 << (v % 8'd3);
    return r;
  endfunction

  function automatic logic [2:0] wrong_of(input logic [2:0] m);
    return {m[1:0], m[2]};
  endfunction

  // Reference x^8+x^6+x^5+x^4+1 LFSR, reset together with the DUT.
  always @(posedge clock or posedge scoreReset) begin
    if (scoreReset) m_lfsr <= 8'hA5;
    else            m_lfsr <= nxt(m_lfsr);
  end

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Called in a SPAWN cycle: predict the mole and check it one cycle later.
  task automatic enter_active(input string tag);
    exp_mole = onehot_of(m_lfsr);
    chk({tag, "_spawn_busy"}, busy, 1);
    step;
    chk({tag, "_mole"}, mole, exp_mole);
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1;
    chk("rst_mole", mole, 0);
    chk("rst_inc", score_inc, 0);
    chk("rst_clr", score_clr, 0);
    chk("rst_misses", misses, 0);
    chk("rst_over", game_over, 0);
    chk("rst_busy", busy, 0);
    scoreReset = 1'b0;
    step;
    chk("idle_busy", busy, 0);

    // Start a game.
    start = 1'b1; step; start = 1'b0;
    chk("start_clr", score_clr, 1);
    chk("start_mole0", mole, 0);
    enter_active("first");
    chk("first_clr_gone", score_clr, 0);

    // Correct press.
    hit = exp_mole; step; hit = 3'b000;
    chk("hit_inc", score_inc, 1);
    chk("hit_mole0", mole, 0);
    step;
    chk("hit_inc_once", score_inc, 0);
    chk("hit_misses", misses, 0);
    enter_active("after_hit");

    // Three timeouts end the game.
    for (int r = 1; r <= 3; r++) begin
      for (int k = 0; k < 3; k++) begin
        tick = 1'b1; step; tick = 1'b0; step;
      end
      chk("pre_timeout_mole", mole, exp_mole);
      tick = 1'b1; step; tick = 1'b0;
      chk("miss_mole0", mole, 0);
      chk("miss_cnt_before", misses, r - 1);
      step;
      chk("miss_cnt", misses, r);
      if (r < 3) enter_active("respawn");
    end
    chk("over_flag", game_over, 1);
    chk("over_busy", busy, 0);
    chk("over_mole", mole, 0);
    tick = 1'b1; step; tick = 1'b0;
    chk("over_tick_ignored", game_over, 1);

    // Restart from OVER.
    start = 1'b1; step; start = 1'b0;
    chk("restart_clr", score_clr, 1);
    chk("restart_misses", misses, 0);
    chk("restart_over", game_over, 0);
    enter_active("restart");

    // Correct press on the final tick: hit wins.
    for (int k = 0; k < 3; k++) begin
      tick = 1'b1; step; tick = 1'b0; step;
    end
    tick = 1'b1; hit = exp_mole; step; tick = 1'b0; hit = 3'b000;
    chk("race_inc", score_inc, 1);
    step;
    chk("race_misses", misses, 0);
    enter_active("race");

    // start while ACTIVE is ignored.
    start = 1'b1; step; start = 1'b0;
    chk("active_start_clr", score_clr, 0);
    chk("active_start_mole", mole, exp_mole);

    // Wrong plus correct in the same cycle: hit.
    hit = exp_mole | wrong_of(exp_mole); step; hit = 3'b000;
    chk("combo_inc", score_inc, 1);
    step;
    enter_active("combo");

    // Wrong button alone.
    hit = wrong_of(exp_mole); step; hit = 3'b000;
`ifdef MOLE_WRONG_PRESS_PENALTY_EN
    chk("wrong_mole0", mole, 0);
    step;
    chk("wrong_misses", misses, 1);
`else
    chk("wrong_mole_kept", mole, exp_mole);
    chk("wrong_inc", score_inc, 0);
    step;
    chk("wrong_misses", misses, 0);
    hit = exp_mole; step; hit = 3'b000;
    chk("wrong_then_hit", score_inc, 1);
    step;
`endif
    enter_active("wrong");

    // Hold the next mole's button from the HIT cycle through SPAWN.
    hit = exp_mole; step;
    chk("held_pre_inc", score_inc, 1);
    hit = onehot_of(nxt(m_lfsr));
    step;
    enter_active("held");
    chk("held_first_inc", score_inc, 0);
    for (int k = 0; k < 3; k++) begin
      step;
      chk("held_no_hit", score_inc, 0);
      chk("held_mole", mole, exp_mole);
    end
    hit = 3'b000; step;
    hit = exp_mole; step; hit = 3'b000;
    chk("held_repress_inc", score_inc, 1);
    step;
    enter_active("pre_reset");

    // Asynchronous reset mid-ACTIVE.
    #3 scoreReset = 1'b1;
    #1;
    chk("arst_mole", mole, 0);
    chk("arst_inc", score_inc, 0);
    chk("arst_clr", score_clr, 0);
    chk("arst_misses", misses, 0);
    chk("arst_over", game_over, 0);
    chk("arst_busy", busy, 0);
    step;
    scoreReset = 1'b0;
    step;
    chk("post_rst_busy", busy, 0);
    chk("post_rst_mole", mole, 0);
    start = 1'b1; step; start = 1'b0;
    chk("post_rst_clr", score_clr, 1);
    enter_active("post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
